conv_input_interface: RTL

Input-side data mover for the convolution layer. It sits directly downstream of the conv layer controller. It executes the controller's PRELOAD, SHIFT and LOAD commands against the image ROM, keeps a KERNEL_SIZE-row line buffer, and feeds one KERNEL_SIZE-word column per SHIFT to the kernel array. Each finished command is reported back to the controller with a one-cycle ack code.

---
 rtl/conv_input_interface_pkg.sv | 33 +++
 rtl/conv_input_interface_line_buffer.sv | 45 ++++
 rtl/conv_input_interface.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/conv_input_interface_pkg.sv
// Shared definitions for the conv layer: geometry, controller cmd/ack codes and the
// input-interface FSM state type.
package conv_layer_defs;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned IMAGE_SIZE  = 8;
    localparam int unsigned ADDR_WIDTH  = 6;
    localparam int unsigned ROM_DEPTH   = 64;

    localparam int unsigned COL_W  = $clog2(IMAGE_SIZE);
    localparam int unsigned ROW_W  = $clog2(KERNEL_SIZE);
    localparam int unsigned NROW_W = $clog2(IMAGE_SIZE);

    localparam logic [1:0] CMD_IDLE          = 2'd0;
    localparam logic [1:0] CMD_PRELOAD_START = 2'd1;
    localparam logic [1:0] CMD_SHIFT_START   = 2'd2;
    localparam logic [1:0] CMD_LOAD_START    = 2'd3;

    localparam logic [1:0] ACK_IDLE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPreloadRd,
        StLoadRd,
        StDrain,
        StAck
    } in_state_e;

endpackage

// File: rtl/conv_input_interface_line_buffer.sv
// KERNEL_SIZE x IMAGE_SIZE word line buffer: single write port, whole-row shift-up,
// and a combinational column read with row 0 in the LSBs.
module conv_line_buffer
    import conv_layer_defs::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  logic [ROW_W-1:0]              i_wr_row,
    input  logic [COL_W-1:0]              i_wr_col,
    input  logic [WIDTH-1:0]              i_wr_data,
    input  logic                          i_shift_up,
    input  logic [COL_W-1:0]              i_rd_col,
    output logic [KERNEL_SIZE*WIDTH-1:0]  o_column
);

    logic [WIDTH-1:0] r_buf [KERNEL_SIZE][IMAGE_SIZE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (i_shift_up) begin
            // Top row keeps its old words; the following reads overwrite all of them.
            for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    r_buf[r][c] <= r_buf[r+1][c];
                end
            end
        end else if (i_wr_en) begin
            r_buf[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    always_comb begin
        o_column = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            o_column[r*WIDTH +: WIDTH] = r_buf[r][i_rd_col];
        end
    end

endmodule

// File: rtl/conv_input_interface.sv
// Executes PRELOAD / SHIFT / LOAD commands from the conv layer controller against the image
// ROM, maintains the line buffer and emits one kernel column per SHIFT.
module conv_input_interface
    import conv_layer_defs::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    input_interface_cmd,
    output logic [1:0]                    input_interface_ack,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [WIDTH-1:0]              rom_data,
    output logic [KERNEL_SIZE*WIDTH-1:0]  column_data,
    output logic                          column_valid
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [NROW_W-1:0] NROW_LAST = NROW_W'(IMAGE_SIZE - 1);

    in_state_e                   r_state, w_state_d;
    logic [COL_W-1:0]            r_col_ptr;
    logic [NROW_W-1:0]           r_next_row;
    logic [ROW_W-1:0]            r_fill_row;
    logic [COL_W-1:0]            r_fill_col;
    logic                        r_rom_en;
    logic [ADDR_WIDTH-1:0]       r_rom_addr;
    logic                        r_cap_valid;
    logic [ROW_W-1:0]            r_cap_row;
    logic [COL_W-1:0]            r_cap_col;
    logic [1:0]                  r_pending_ack;
    logic [KERNEL_SIZE*WIDTH-1:0] r_col_data;
    logic                        r_col_valid;

    logic                        w_start_preload, w_start_load, w_do_shift, w_last_issue;
    logic [KERNEL_SIZE*WIDTH-1:0] w_column;

    // PRELOAD ends on the last column of the top row; LOAD fills only the top row.
    assign w_last_issue = (r_fill_row == ROW_LAST) && (r_fill_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_start_preload = 1'b0;
        w_start_load    = 1'b0;
        w_do_shift      = 1'b0;
        unique case (r_state)
            StIdle: begin
                case (input_interface_cmd)
                    CMD_PRELOAD_START: begin
                        w_start_preload = 1'b1;
                        w_state_d       = StPreloadRd;
                    end
                    CMD_LOAD_START: begin
                        w_start_load = 1'b1;
                        w_state_d    = StLoadRd;
                    end
                    CMD_SHIFT_START: begin
                        w_do_shift = 1'b1;
                        w_state_d  = StAck;
                    end
                    default: ;
                endcase
            end
            StPreloadRd, StLoadRd: if (w_last_issue) w_state_d = StDrain;
            StDrain:               w_state_d = StAck;
            StAck:                 w_state_d = StIdle;
            default:               w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_ptr     <= '0;
            r_next_row    <= '0;
            r_fill_row    <= '0;
            r_fill_col    <= '0;
            r_rom_en      <= 1'b0;
            r_rom_addr    <= '0;
            r_cap_valid   <= 1'b0;
            r_cap_row     <= '0;
            r_cap_col     <= '0;
            r_pending_ack <= ACK_IDLE;
            r_col_data    <= '0;
            r_col_valid   <= 1'b0;
        end else begin
            // Data for the address issued this cycle returns next cycle.
            r_cap_valid <= r_rom_en;
            r_cap_row   <= r_fill_row;
            r_cap_col   <= r_fill_col;
            r_col_valid <= 1'b0;
            if (w_start_preload) begin
                r_rom_en      <= 1'b1;
                r_rom_addr    <= '0;
                r_fill_row    <= '0;
                r_fill_col    <= '0;
                r_pending_ack <= ACK_PRELOAD_FIN;
            end
            if (w_start_load) begin
                r_rom_en      <= 1'b1;
                r_rom_addr    <= ADDR_WIDTH'(r_next_row * IMAGE_SIZE);
                r_fill_row    <= ROW_LAST;
                r_fill_col    <= '0;
                r_pending_ack <= ACK_LOAD_FIN;
            end
            if (w_do_shift) begin
                r_col_data    <= w_column;
                r_col_valid   <= 1'b1;
                r_col_ptr     <= (r_col_ptr == COL_LAST) ? '0 : r_col_ptr + 1'b1;
                r_pending_ack <= ACK_SHIFT_FIN;
            end
            if (r_rom_en) begin
                if (w_last_issue) begin
                    r_rom_en <= 1'b0;
                end else begin
                    r_rom_addr <= r_rom_addr + 1'b1;
                    if (r_fill_col == COL_LAST) begin
                        r_fill_col <= '0;
                        r_fill_row <= r_fill_row + 1'b1;
                    end else begin
                        r_fill_col <= r_fill_col + 1'b1;
                    end
                end
            end
            if (r_state == StDrain) begin
                r_col_ptr  <= '0;
                r_next_row <= (r_pending_ack == ACK_PRELOAD_FIN) ? NROW_W'(KERNEL_SIZE) :
                              (r_next_row == NROW_LAST) ? '0 : r_next_row + 1'b1;
            end
        end
    end

    conv_line_buffer u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (r_cap_valid),
        .i_wr_row   (r_cap_row),
        .i_wr_col   (r_cap_col),
        .i_wr_data  (rom_data),
        .i_shift_up (w_start_load),
        .i_rd_col   (r_col_ptr),
        .o_column   (w_column)
    );

    assign input_interface_ack = (r_state == StAck) ? r_pending_ack : ACK_IDLE;
    assign rom_en              = r_rom_en;
    assign rom_addr            = r_rom_addr;
    assign column_data         = r_col_data;
    assign column_valid        = r_col_valid;

endmodule
